// File: rtl/pic_inta_sequencer.sv
// 8259-style priority resolver and 8086 two-pulse INTA sequencer.
// Owns the in-service register, INT generation, vector drive and EOI/AEOI clearing.
module pic_inta_sequencer #(
  parameter int unsigned NUM_IR = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic       inta_n,
  input  logic       aeoi_mode,
  input  logic [4:0] vector_base,
  input  logic       eoi_strobe,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [1:0] inta_count,
  output logic       clear_valid,
  output logic [2:0] clear_level,
  output logic [7:0] isr,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       spurious
);

  typedef enum logic [1:0] {StIdle, StPend, StAck1, StAck2} state_e;

  state_e     state;
  logic [2:0] lvl;
  logic       inta_n_q;

  logic [7:0] req;
  logic [3:0] p_idx;
  logic [3:0] s_idx;
  logic       eligible;
  logic       inta_edge;
  logic [7:0] eoi_clr;
  logic [7:0] aeoi_clr;
  logic [7:0] isr_set;
  logic [7:0] isr_d;

  assign req       = irr & ~imr;
  assign inta_edge = inta_n_q & ~inta_n;

  // Index 8 stands for "none set", so an empty ISR never blocks a request.
  always_comb begin
    p_idx = 4'd8;
    s_idx = 4'd8;
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (req[i]) p_idx = 4'(i);
      if (isr[i]) s_idx = 4'(i);
    end
  end

  assign eligible = (req != 8'd0) && (p_idx < s_idx);

  // EOI and AEOI clears are applied before the acknowledge set, so a set wins.
  always_comb begin
    eoi_clr  = 8'd0;
    aeoi_clr = 8'd0;
    isr_set  = 8'd0;
    if (eoi_strobe) begin
      if (eoi_specific)        eoi_clr = 8'd1 << eoi_level;
      else if (s_idx < 4'd8)   eoi_clr = 8'd1 << s_idx[2:0];
    end
    if (state == StAck2 && inta_n && aeoi_mode && !spurious) aeoi_clr = 8'd1 << lvl;
    if (state == StPend && inta_edge && eligible)            isr_set  = 8'd1 << p_idx[2:0];
    isr_d = (isr & ~(eoi_clr | aeoi_clr)) | isr_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      lvl         <= 3'd0;
      inta_n_q    <= 1'b1;
      int_out     <= 1'b0;
      inta_count  <= 2'd0;
      clear_valid <= 1'b0;
      clear_level <= 3'd0;
      isr         <= 8'd0;
      data_out    <= 8'd0;
      data_oe     <= 1'b0;
      spurious    <= 1'b0;
    end else begin
      inta_n_q    <= inta_n;
      isr         <= isr_d;
      clear_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (eligible) begin
            int_out <= 1'b1;
            state   <= StPend;
          end
        end
        StPend: begin
          if (inta_edge) begin
            if (eligible) begin
              lvl         <= p_idx[2:0];
              clear_valid <= 1'b1;
              clear_level <= p_idx[2:0];
              spurious    <= 1'b0;
            end else begin
              lvl      <= 3'd7;
              spurious <= 1'b1;
            end
            int_out    <= 1'b0;
            inta_count <= 2'd1;
            state      <= StAck1;
          end
        end
        StAck1: begin
          if (inta_edge) begin
            inta_count <= 2'd2;
            data_out   <= {vector_base, lvl};
            data_oe    <= 1'b1;
            state      <= StAck2;
          end
        end
        StAck2: begin
          if (inta_n) begin
            data_oe    <= 1'b0;
            data_out   <= 8'd0;
            inta_count <= 2'd0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Self-checking bench for pic_inta_sequencer: directed scenarios plus randomized
// request/mask/EOI traffic checked against a transaction-level ISR model.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irr, imr;
  logic       inta_n, aeoi_mode;
  logic [4:0] vector_base;
  logic       eoi_strobe, eoi_specific;
  logic [2:0] eoi_level;
  logic       int_out;
  logic [1:0] inta_count;
  logic       clear_valid;
  logic [2:0] clear_level;
  logic [7:0] isr, data_out;
  logic       data_oe, spurious;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] m_isr;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.NUM_IR(8)) dut (
    .clk(clk), .reset(reset), .irr(irr), .imr(imr), .inta_n(inta_n),
    .aeoi_mode(aeoi_mode), .vector_base(vector_base), .eoi_strobe(eoi_strobe),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .int_out(int_out),
    .inta_count(inta_count), .clear_valid(clear_valid), .clear_level(clear_level),
    .isr(isr), .data_out(data_out), .data_oe(data_oe), .spurious(spurious)
  );

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic bit elig(input logic [7:0] r, input logic [7:0] m, input logic [7:0] s);
    int p;
    p = lowest(r & ~m);
    return (p < 8) && (p < lowest(s));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; irr = 8'd0; imr = 8'd0; inta_n = 1'b1; aeoi_mode = 1'b0;
    vector_base = 5'd0; eoi_strobe = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0;
    m_isr = 8'd0;
    tick();
    reset = 1'b0;
  endtask

  // Full two-pulse acknowledge starting from a raised INT.
  task automatic handshake(input logic [2:0] lv, input bit spur);
    logic [7:0] vec;
    vec = {vector_base, lv};
    inta_n = 1'b0;
    tick();
    if (!spur) m_isr[lv] = 1'b1;
    tests_run++;
    if (int_out !== 1'b0 || inta_count !== 2'd1 || clear_valid !== !spur ||
        isr !== m_isr || spurious !== spur || (!spur && clear_level !== lv)) begin
      tests_failed++;
      $display("FAIL inta1: int=%b cnt=%0d cv=%b cl=%0d isr=%h sp=%b, want int=0 cnt=1 cv=%b cl=%0d isr=%h sp=%b",
               int_out, inta_count, clear_valid, clear_level, isr, spurious, !spur, lv, m_isr, spur);
    end
    inta_n = 1'b1;
    tick();
    tests_run++;
    if (clear_valid !== 1'b0 || inta_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL gap: cv=%b cnt=%0d, want cv=0 cnt=1", clear_valid, inta_count);
    end
    inta_n = 1'b0;
    tick();
    tick();
    tests_run++;
    if (inta_count !== 2'd2 || data_oe !== 1'b1 || data_out !== vec) begin
      tests_failed++;
      $display("FAIL inta2: cnt=%0d oe=%b data=%h, want cnt=2 oe=1 data=%h",
               inta_count, data_oe, data_out, vec);
    end
    inta_n = 1'b1;
    tick();
    if (aeoi_mode && !spur) m_isr[lv] = 1'b0;
    tests_run++;
    if (inta_count !== 2'd0 || data_oe !== 1'b0 || data_out !== 8'd0 || isr !== m_isr) begin
      tests_failed++;
      $display("FAIL release: cnt=%0d oe=%b data=%h isr=%h, want cnt=0 oe=0 data=00 isr=%h",
               inta_count, data_oe, data_out, isr, m_isr);
    end
  endtask

  task automatic send_eoi(input bit spec, input logic [2:0] lv);
    int s;
    eoi_strobe = 1'b1; eoi_specific = spec; eoi_level = lv;
    tick();
    eoi_strobe = 1'b0;
    s = lowest(m_isr);
    if (spec) m_isr[lv] = 1'b0;
    else if (s < 8) m_isr[s] = 1'b0;
    tests_run++;
    if (isr !== m_isr) begin
      tests_failed++;
      $display("FAIL eoi spec=%b lv=%0d: isr=%h, want %h", spec, lv, isr, m_isr);
    end
  endtask

  task automatic expect_int(input string name, input logic exp);
    tests_run++;
    if (int_out !== exp) begin
      tests_failed++;
      $display("FAIL %s: int_out=%b, want %b", name, int_out, exp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({int_out, inta_count, clear_valid, clear_level, isr, data_out, data_oe, spurious} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: outputs=%h, want 0",
               {int_out, inta_count, clear_valid, clear_level, isr, data_out, data_oe, spurious});
    end
  endtask

  task automatic test_basic();
    do_reset();
    vector_base = 5'b01000;
    irr = 8'b0000_0100;
    tick();
    expect_int("basic_int", 1'b1);
    handshake(3'd2, 1'b0);
    irr = 8'd0;
    tests_run++;
    if (data_out !== 8'd0 || isr !== 8'b0000_0100) begin
      tests_failed++;
      $display("FAIL basic_end: isr=%h, want 04", isr);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    vector_base = 5'b10101;
    irr = 8'b0000_0100;
    tick();
    handshake(3'd2, 1'b0);
    irr = 8'b1000_0001;
    tick();
    expect_int("nest_ir0", 1'b1);
    handshake(3'd0, 1'b0);
    irr = 8'd0;
    send_eoi(1'b0, 3'd0);
    irr = 8'b1000_0000;
    tick();
    tick();
    expect_int("nest_ir7_blocked", 1'b0);
    irr = 8'd0;
  endtask

  task automatic test_aeoi();
    do_reset();
    aeoi_mode = 1'b1;
    vector_base = 5'b11001;
    irr = 8'b0010_0000;
    tick();
    expect_int("aeoi_int", 1'b1);
    handshake(3'd5, 1'b0);
    irr = 8'd0;
    aeoi_mode = 1'b0;
  endtask

  task automatic test_spurious();
    do_reset();
    vector_base = 5'b00110;
    irr = 8'b0001_0000;
    tick();
    expect_int("spur_int", 1'b1);
    irr = 8'd0;
    tick();
    expect_int("spur_int_held", 1'b1);
    handshake(3'd7, 1'b1);
  endtask

  task automatic test_mask_eoi();
    do_reset();
    imr = 8'hFF; irr = 8'hFF;
    tick();
    tick();
    expect_int("all_masked", 1'b0);
    imr = 8'd0; irr = 8'b0000_1000;
    tick();
    handshake(3'd3, 1'b0);
    irr = 8'b0000_0001;
    tick();
    handshake(3'd0, 1'b0);
    irr = 8'd0;
    send_eoi(1'b1, 3'd3);
    send_eoi(1'b0, 3'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    irr = 8'b0000_0010;
    tick();
    inta_n = 1'b0;
    tick();
    tests_run++;
    if (isr !== 8'b0000_0010 || inta_count !== 2'd1) begin
      tests_failed++;
      $display("FAIL mid_ack1: isr=%h cnt=%0d, want 02 1", isr, inta_count);
    end
    #2 reset = 1'b1;
    inta_n = 1'b1;
    #1;
    tests_run++;
    if ({int_out, inta_count, clear_valid, clear_level, isr, data_out, data_oe, spurious} !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: outputs=%h, want 0",
               {int_out, inta_count, clear_valid, clear_level, isr, data_out, data_oe, spurious});
    end
    #2 reset = 1'b0;
    m_isr = 8'd0;
    tick();
    expect_int("int_after_reset", 1'b1);
    do_reset();
  endtask

  task automatic test_random();
    logic exp;
    int   p;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      irr = 8'($urandom);
      imr = 8'($urandom & $urandom);
      aeoi_mode = 1'($urandom);
      vector_base = 5'($urandom);
      tick();
      exp = elig(irr, imr, m_isr);
      expect_int("rand_int", exp);
      if (exp) begin
        case ($urandom % 4)
          0: irr = 8'd0;
          1: imr = 8'($urandom);
          default: ;
        endcase
        if (elig(irr, imr, m_isr)) begin
          p = lowest(irr & ~imr);
          handshake(3'(p), 1'b0);
        end else begin
          handshake(3'd7, 1'b1);
        end
      end else begin
        tick();
        expect_int("rand_int_hold", 1'b0);
      end
      irr = 8'd0;
      if ($urandom % 2 == 0) send_eoi(1'($urandom), 3'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_aeoi();
    test_spurious();
    test_mask_eoi();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
